// File: rtl/lcd_backlight_sched_pkg.sv
// Shared definitions for the LCD backlight scheduler and its timing helpers.
package lcd_backlight_sched_pkg;

  localparam int LEVEL_W   = 5;
  localparam int LEVEL_MAX = 31;
  localparam int US_PER_MS = 1000;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_RAMP   = 2'd1;
  localparam logic [1:0] ST_STEADY = 2'd2;

  typedef logic [LEVEL_W-1:0] level_t;

  function automatic level_t min_level(input level_t a, input level_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_backlight_sched_tick_gen.sv
// Free-running microsecond / millisecond strobe generator shared by LCD timing blocks.
module lcd_tick_gen
  import lcd_backlight_sched_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic srst,
  output logic us_tick,
  output logic ms_tick
);

  localparam int DIV   = CLK_HZ / 1000000;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_W  = $clog2(US_PER_MS);

  logic [DIV_W-1:0] div_cnt;
  logic [MS_W-1:0]  us_cnt;

  assign us_tick = (div_cnt == DIV_W'(DIV - 1));
  assign ms_tick = us_tick && (us_cnt == MS_W'(US_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt <= '0;
      us_cnt  <= '0;
    end else begin
      div_cnt <= us_tick ? '0 : div_cnt + DIV_W'(1);
      if (us_tick) us_cnt <= ms_tick ? '0 : us_cnt + MS_W'(1);
    end
  end

endmodule

// File: rtl/lcd_backlight_sched.sv
// Arbitrates user/idle/force-off/cap into a target level and ramps the EZDim level one step per STEP_US.
module lcd_backlight_sched
  import lcd_backlight_sched_pkg::*;
#(
  parameter int          CLK_HZ     = 100000000,
  parameter int          STEP_US    = 2000,
  parameter int          IDLE_MS    = 60000,
  parameter logic [4:0]  DIM_LEVEL  = 5'd4,
  parameter logic [4:0]  INIT_LEVEL = 5'd20
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [4:0] user_level,
  input  logic       user_wr,
  input  logic       activity,
  input  logic       force_off,
  input  logic [4:0] cap_level,
  output logic [4:0] level_out,
  output logic       ramping,
  output logic       dimmed
);

  localparam int IDLE_W = (IDLE_MS > 0) ? $clog2(IDLE_MS + 1) : 1;
  localparam int STEP_W = (STEP_US > 1) ? $clog2(STEP_US + 1) : 1;

  logic              us_tick, ms_tick;
  logic [IDLE_W-1:0] idle_cnt;
  logic [STEP_W-1:0] step_cnt;
  level_t            user_reg, target, raw, next_lvl;
  logic [1:0]        state;
  logic              step_due;

  lcd_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .srst    (srst),
    .us_tick (us_tick),
    .ms_tick (ms_tick)
  );

  // Idle timer saturates at IDLE_MS; a clear in the timeout cycle wins.
  always_ff @(posedge clk) begin
    if (srst || user_wr || activity)
      idle_cnt <= '0;
    else if (ms_tick && (IDLE_MS != 0) && (idle_cnt != IDLE_W'(IDLE_MS)))
      idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  assign dimmed = (IDLE_MS != 0) && (idle_cnt == IDLE_W'(IDLE_MS));

  always_comb begin
    raw = user_reg;
    if (force_off)   raw = '0;
    else if (dimmed) raw = min_level(user_reg, DIM_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      user_reg <= INIT_LEVEL;
      target   <= '0;
    end else begin
      if (user_wr) user_reg <= user_level;
      target <= min_level(raw, cap_level);
    end
  end

  assign step_due = us_tick && (step_cnt == STEP_W'(STEP_US - 1));
  assign next_lvl = (target > level_out) ? level_out + 5'd1 : level_out - 5'd1;
  assign ramping  = (state == ST_RAMP);

  always_ff @(posedge clk) begin
    if (srst || force_off) begin
      state     <= ST_OFF;
      level_out <= '0;
      step_cnt  <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          level_out <= '0;
          if (target != '0) begin
            step_cnt <= '0;
            state    <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (level_out == target) begin
            state <= ST_STEADY;
          end else if (step_due) begin
            // direction comes from the current target, so mid-ramp retargets reverse cleanly
            level_out <= next_lvl;
            step_cnt  <= '0;
            if (next_lvl == target) state <= ST_STEADY;
          end else if (us_tick) begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        ST_STEADY: begin
          if (target != level_out) begin
            step_cnt <= '0;
            state    <= ST_RAMP;
          end
        end
        default: begin
          state     <= ST_OFF;
          level_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_backlight_sched.sv
// Randomized + directed bench for lcd_backlight_sched against a deadline-based reference model.
module tb_lcd_backlight_sched;

  localparam int CLK_HZ = 10000000;
  localparam int STEP_US = 5;
  localparam int IDLE_MS = 2;
  localparam int DIM = 4;
  localparam int INIT = 20;
  localparam int DIV = CLK_HZ / 1000000;
  localparam int CYC_PER_MS = DIV * 1000;

  logic       clk = 0;
  logic       srst = 1;
  logic [4:0] user_level = 0;
  logic       user_wr = 0;
  logic       activity = 0;
  logic       force_off = 0;
  logic [4:0] cap_level = 5'd31;
  logic [4:0] level_out;
  logic       ramping, dimmed;

  lcd_backlight_sched #(
    .CLK_HZ(CLK_HZ), .STEP_US(STEP_US), .IDLE_MS(IDLE_MS),
    .DIM_LEVEL(5'(DIM)), .INIT_LEVEL(5'(INIT))
  ) dut (
    .clk(clk), .srst(srst), .user_level(user_level), .user_wr(user_wr),
    .activity(activity), .force_off(force_off), .cap_level(cap_level),
    .level_out(level_out), .ramping(ramping), .dimmed(dimmed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges since reset, absolute us/ms counts, ms count at last
  // activity, and the absolute us count at which the next ramp step is due.
  int m_n, m_us, m_ms, m_clr_ms, m_user, m_tgt, m_lvl, m_next_us;
  int m_ph;  // 0 off, 1 ramping, 2 steady

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int m_dim();
    return (IDLE_MS != 0 && (m_ms - m_clr_ms) >= IDLE_MS) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int raw;
    int tgt_n;
    int dim_o;
    bit ust;
    if (srst) begin
      m_n = 0; m_us = 0; m_ms = 0; m_clr_ms = 0;
      m_user = INIT; m_tgt = 0; m_lvl = 0; m_ph = 0; m_next_us = 0;
    end else begin
      dim_o = m_dim();
      m_n++;
      ust = (m_n % DIV) == 0;
      if (ust) m_us++;
      if (m_n % CYC_PER_MS == 0) m_ms++;
      if (user_wr || activity) m_clr_ms = m_ms;
      raw = force_off ? 0 : (dim_o != 0 ? imin(m_user, DIM) : m_user);
      tgt_n = imin(raw, int'(cap_level));
      if (force_off) begin
        m_lvl = 0; m_ph = 0;
      end else if (m_ph == 0) begin
        if (m_tgt != 0) begin m_ph = 1; m_next_us = m_us + STEP_US; end
      end else if (m_ph == 1) begin
        if (m_lvl == m_tgt) m_ph = 2;
        else if (ust && m_us == m_next_us) begin
          m_lvl = (m_tgt > m_lvl) ? m_lvl + 1 : m_lvl - 1;
          m_next_us = m_us + STEP_US;
          if (m_lvl == m_tgt) m_ph = 2;
        end
      end else begin
        if (m_tgt != m_lvl) begin m_ph = 1; m_next_us = m_us + STEP_US; end
      end
      m_tgt = tgt_n;
      if (user_wr) m_user = int'(user_level);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle{lvl,ramp,dim}", {level_out, ramping, dimmed},
        m_lvl * 4 + (m_ph == 1 ? 2 : 0) + m_dim());
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int lvl);
    user_level = 5'(lvl); user_wr = 1; tick(); user_wr = 0;
  endtask

  task automatic wait_level(input string tag, input int lvl, input int budget);
    int k;
    k = 0;
    while (int'(level_out) != lvl && k < budget) begin tick(); k++; end
    chk(tag, int'(level_out), lvl);
  endtask

  initial begin
    int last, gap_k;
    bit found;
    // reset
    srst = 1; cyc(3);
    chk("reset_level", level_out, 0);
    chk("reset_ramping", ramping, 0);
    chk("reset_dimmed", dimmed, 0);
    srst = 0;

    // 1: power-up fade 0 -> 20, steps 50 clocks apart
    last = -1; gap_k = 0;
    for (int i = 0; i < 1200; i++) begin
      logic [4:0] prev;
      prev = level_out;
      tick();
      if (level_out != prev) begin
        if (last >= 0) chk("step_gap", i - last, STEP_US * DIV);
        last = i; gap_k++;
      end
    end
    chk("powerup_steps", gap_k, INIT);
    chk("powerup_level", level_out, 20);
    chk("powerup_ramping", ramping, 0);

    // 2: down to 17
    wr(17); cyc(250);
    chk("down17_level", level_out, 17);

    // 3: auto-dim and wake
    wr(20); cyc(300);
    chk("back20_level", level_out, 20);
    found = 0;
    for (int i = 0; i < 3 * CYC_PER_MS && !found; i++) begin
      tick();
      if (dimmed) found = 1;
    end
    chk("dim_reached", dimmed, 1);
    cyc(1000);
    chk("dim_level", level_out, DIM);
    activity = 1; tick(); activity = 0;
    chk("dim_drop", dimmed, 0);
    cyc(1000);
    chk("wake_level", level_out, 20);

    // activity exactly on the timeout edge
    found = 0;
    for (int i = 0; i < 3 * CYC_PER_MS && !found; i++) begin
      if ((m_n + 1) % CYC_PER_MS == 0 && (m_ms - m_clr_ms) == IDLE_MS - 1) found = 1;
      else tick();
    end
    chk("timeout_edge_found", int'(found), 1);
    activity = 1; tick(); activity = 0;
    chk("coincident_dim", dimmed, 0);
    cyc(20);
    chk("coincident_dim_later", dimmed, 0);

    // 4: cap
    cap_level = 10; cyc(700);
    chk("cap10_level", level_out, 10);
    wr(25); cyc(300);
    chk("cap10_hold", level_out, 10);
    cap_level = 31; cyc(900);
    chk("uncap25_level", level_out, 25);

    // 5: force_off mid-ramp at 12
    wr(5);
    wait_level("reach12", 12, 1000);
    force_off = 1; tick();
    chk("force_off_level", level_out, 0);
    chk("force_off_ramping", ramping, 0);
    cyc(5);
    force_off = 0;
    cyc(400);
    chk("refade_level", level_out, 5);

    // 6: srst mid-ramp at 9
    wr(15);
    wait_level("reach9", 9, 600);
    srst = 1; tick(); srst = 0;
    chk("srst_level", level_out, 0);
    chk("srst_dimmed", dimmed, 0);
    cyc(1200);
    chk("srst_refade_level", level_out, INIT);

    // random soak
    for (int i = 0; i < 12000; i++) begin
      user_wr    = ($urandom % 400) == 0;
      user_level = 5'($urandom % 32);
      activity   = ($urandom % 3000) == 0;
      if ($urandom % 700 == 0) cap_level = ($urandom % 2) ? 5'd31 : 5'($urandom % 32);
      if ($urandom % 1500 == 0) force_off = ~force_off;
      srst       = ($urandom % 6000) == 0;
      tick();
      user_wr = 0; activity = 0; srst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
